// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one registered memory port between instruction fetch
// and data access, with flush-aware fetch dropping and a per-transfer timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ready,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    IF_DROP  = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q, bus_we_q, bus_err_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] if_data_q, mem_rdata_q;
  logic        if_ready_q, mem_ready_q;

  // A requester whose ready pulse is showing this cycle is finishing, not asking again.
  logic mem_elig, if_elig, cnt_last;
  assign mem_elig = mem_ce & ~mem_ready_q;
  assign if_elig  = if_ce & ~if_ready_q;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_sel_q   <= 4'd0;
      bus_wdata_q <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_elig) begin
            state_q     <= MEM_BUSY;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_addr_q  <= mem_addr;
            bus_sel_q   <= mem_sel;
            bus_wdata_q <= mem_wdata;
          end else if (if_elig && !flush) begin
            state_q     <= IF_BUSY;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr;
            bus_sel_q   <= 4'b1111;
            bus_wdata_q <= 32'd0;
          end
        end
        MEM_BUSY: begin
          if (bus_ack) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            mem_rdata_q <= bus_rdata;
            mem_ready_q <= 1'b1;
          end else if (cnt_last) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            mem_rdata_q <= 32'd0;
            mem_ready_q <= 1'b1;
            bus_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        IF_BUSY: begin
          // Flushed fetch: the bus transfer must still finish, but its data is discarded.
          if (flush) begin
            if (bus_ack) begin
              state_q   <= IDLE;
              bus_req_q <= 1'b0;
            end else begin
              state_q <= IF_DROP;
              cnt_q   <= 8'd0;
            end
          end else if (bus_ack) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            if_data_q  <= bus_rdata;
            if_ready_q <= 1'b1;
          end else if (cnt_last) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            if_data_q  <= 32'd0;
            if_ready_q <= 1'b1;
            bus_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        IF_DROP: begin
          if (bus_ack) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
          end else if (cnt_last) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_data   = if_data_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;
  assign stallreq  = (mem_ce & ~mem_ready_q) | (if_ce & ~if_ready_q & ~flush);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT=4): fetch, contention, flush/drop,
// timeout, late ack and mid-transfer reset, with hand-computed expectations.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ready;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce(if_ce), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq(stallreq), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_ce = 0; if_addr = 0; mem_ce = 0; mem_we = 0; mem_addr = 0;
    mem_sel = 0; mem_wdata = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic ack_with(input logic [31:0] d);
    bus_ack = 1; bus_rdata = d;
    exp_q.push_back(d);
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    step(); step();
    rst = 1;
    step();

    // plain fetch, ack on third bus cycle
    if_ce = 1; if_addr = 32'h0000_0004;
    step();
    check("f_bus_req", {31'd0, bus_req}, 32'd1);
    check("f_bus_addr", bus_addr, 32'h4);
    check("f_bus_we", {31'd0, bus_we}, 32'd0);
    check("f_bus_sel", {28'd0, bus_sel}, 32'hF);
    check("f_stall_busy", {31'd0, stallreq}, 32'd1);
    step(); step();
    ack_with(32'h3401_0020);
    step();
    bus_ack = 0;
    check("f_if_ready", {31'd0, if_ready}, 32'd1);
    check("f_if_data", if_data, exp_q.pop_front());
    check("f_stall_ready", {31'd0, stallreq}, 32'd0);
    check("f_bus_req_off", {31'd0, bus_req}, 32'd0);
    if_ce = 0;
    step();
    check("f_if_ready_pulse", {31'd0, if_ready}, 32'd0);
    check("f_if_data_hold", if_data, 32'h3401_0020);

    // contention: store wins, fetch follows
    if_ce = 1; if_addr = 32'h0000_0008;
    mem_ce = 1; mem_we = 1; mem_addr = 32'h100; mem_sel = 4'b0011; mem_wdata = 32'hBEEF;
    #1;
    check("c_stall_req", {31'd0, stallreq}, 32'd1);
    step();
    check("c_st_we", {31'd0, bus_we}, 32'd1);
    check("c_st_addr", bus_addr, 32'h100);
    check("c_st_sel", {28'd0, bus_sel}, 32'h3);
    check("c_st_wdata", bus_wdata, 32'hBEEF);
    check("c_stall_st", {31'd0, stallreq}, 32'd1);
    ack_with(32'hAAAA_5555);
    step();
    bus_ack = 0;
    check("c_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("c_mem_rdata", mem_rdata, exp_q.pop_front());
    check("c_if_ready_early", {31'd0, if_ready}, 32'd0);
    check("c_stall_mid", {31'd0, stallreq}, 32'd1);
    mem_ce = 0; mem_we = 0;
    step();
    check("c_f_bus_req", {31'd0, bus_req}, 32'd1);
    check("c_f_addr", bus_addr, 32'h8);
    check("c_f_we", {31'd0, bus_we}, 32'd0);
    check("c_f_wdata", bus_wdata, 32'd0);
    check("c_mem_ready_pulse", {31'd0, mem_ready}, 32'd0);
    check("c_stall_f", {31'd0, stallreq}, 32'd1);
    ack_with(32'h1234_5678);
    step();
    bus_ack = 0;
    check("c_if_ready", {31'd0, if_ready}, 32'd1);
    check("c_if_data", if_data, exp_q.pop_front());
    check("c_stall_done", {31'd0, stallreq}, 32'd0);
    if_ce = 0;
    step();

    // flush during fetch, ack three cycles later
    if_ce = 1; if_addr = 32'h0000_000C;
    step();
    check("fl_busy", {30'd0, dbg_state}, 32'd1);
    flush = 1;
    #1;
    check("fl_stall", {31'd0, stallreq}, 32'd0);
    step();
    flush = 0; if_ce = 0;
    check("fl_drop_state", {30'd0, dbg_state}, 32'd3);
    check("fl_drop_req", {31'd0, bus_req}, 32'd1);
    step();
    check("fl_drop_req2", {31'd0, bus_req}, 32'd1);
    check("fl_no_ready", {31'd0, if_ready}, 32'd0);
    bus_ack = 1; bus_rdata = 32'hDEAD_DEAD;
    step();
    bus_ack = 0;
    check("fl_end_ready", {31'd0, if_ready}, 32'd0);
    check("fl_end_req", {31'd0, bus_req}, 32'd0);
    check("fl_data_hold", if_data, 32'h1234_5678);
    if_ce = 1; if_addr = 32'h0000_0020;
    step();
    check("fl_new_addr", bus_addr, 32'h20);
    ack_with(32'h5555_0000);
    step();
    bus_ack = 0;
    check("fl_new_ready", {31'd0, if_ready}, 32'd1);
    check("fl_new_data", if_data, exp_q.pop_front());
    if_ce = 0;
    step();

    // flush and ack in the same IF_BUSY cycle
    if_ce = 1; if_addr = 32'h0000_0040;
    step();
    flush = 1; bus_ack = 1; bus_rdata = 32'h9999_9999;
    step();
    flush = 0; bus_ack = 0; if_ce = 0;
    check("fa_state", {30'd0, dbg_state}, 32'd0);
    check("fa_no_ready", {31'd0, if_ready}, 32'd0);
    check("fa_req_off", {31'd0, bus_req}, 32'd0);
    check("fa_data_hold", if_data, 32'h5555_0000);
    step();

    // timeout on a load with no ack
    mem_ce = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to_req_c%0d", i), {31'd0, bus_req}, 32'd1);
    end
    step();
    check("to_req_off", {31'd0, bus_req}, 32'd0);
    check("to_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("to_mem_rdata", mem_rdata, 32'd0);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    mem_ce = 0;
    step();
    check("to_err_pulse", {31'd0, bus_err}, 32'd0);

    // late ack in IDLE is ignored
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack = 0;
    check("la_if_ready", {31'd0, if_ready}, 32'd0);
    check("la_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("la_mem_rdata", mem_rdata, 32'd0);
    check("la_bus_req", {31'd0, bus_req}, 32'd0);

    // asynchronous reset in the middle of a store
    mem_ce = 1; mem_we = 1; mem_addr = 32'h300; mem_sel = 4'hF; mem_wdata = 32'h77;
    step();
    check("rs_busy", {31'd0, bus_req}, 32'd1);
    #2 rst = 0;
    #1;
    check("rs_req_now", {31'd0, bus_req}, 32'd0);
    check("rs_state_now", {30'd0, dbg_state}, 32'd0);
    check("rs_if_data", if_data, 32'd0);
    step();
    check("rs_no_ready", {31'd0, mem_ready}, 32'd0);
    rst = 1;
    step();
    check("rs_fresh_req", {31'd0, bus_req}, 32'd1);
    check("rs_fresh_addr", bus_addr, 32'h300);
    ack_with(32'h0000_0077);
    step();
    bus_ack = 0;
    check("rs_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rs_mem_rdata", mem_rdata, exp_q.pop_front());
    mem_ce = 0;
    step();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255 (range 2..255): bus cycles allowed per transfer before abort.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 if_ce  in  1  fetch request from PC stage; held high until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_data  out  32  fetched instruction; valid when if_ready=1.
REQ-007 if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 mem_ce  in  1  data request from MEM stage; held high until mem_ready.
REQ-009 mem_we / mem_addr / mem_sel / mem_wdata  in  1/32/4/32  write enable, address, byte lanes, store data.
REQ-010 mem_rdata  out  32  load data; valid when mem_ready=1.
REQ-011 mem_ready  out  1  one-cycle data completion pulse.
REQ-012 flush  in  1  pipeline flush; cancels fetch only.
REQ-013 bus_req / bus_we / bus_addr / bus_sel / bus_wdata  out  1/1/32/4/32  registered shared memory port.
REQ-014 bus_ack / bus_rdata  in  1/32  transfer completion and read data from memory.
REQ-015 stallreq  out  1  stall request to pipeline controller.
REQ-016 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 The block SHALL use states IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
REQ-018 IDLE: eligible requester = ce high and own ready low this cycle; mem eligible -> MEM_BUSY; else if eligible and flush=0 -> IF_BUSY; else stay IDLE.
REQ-019 On entering a BUSY state the block SHALL register bus_req=1 and latch address/sel/we/wdata (fetch: we=0, sel=4'b1111, wdata=0); bus outputs SHALL stay stable until transfer ends.
REQ-020 MEM_BUSY/IF_BUSY with bus_ack=1: capture bus_rdata into mem_rdata/if_data, pulse matching ready next cycle, bus_req=0 next cycle, return to IDLE.
REQ-021 Minimum latency: request seen cycle N, bus_req high N+1, ack at N+1 -> ready high N+2.
REQ-022 IF_BUSY with flush=1 (with or without bus_ack): no if_ready; if bus_ack=1 -> IDLE, else -> IF_DROP.
REQ-023 IF_DROP: keep bus_req high, discard data; on bus_ack -> IDLE without if_ready.
REQ-024 flush SHALL never affect MEM_BUSY or a pending mem request.
REQ-025 mem_ce and if_ce both eligible in IDLE: data transfer first; fetch issued from IDLE after mem_ready cycle.
REQ-026 An 8-bit counter SHALL clear on entering any BUSY/DROP state and increment each cycle without bus_ack.
REQ-027 Counter reaching TIMEOUT without ack: drop bus_req, return to IDLE, pulse bus_err; in MEM_BUSY/IF_BUSY also pulse ready with data 32'h0; in IF_DROP no ready.
REQ-028 stallreq SHALL be combinational: (mem_ce & ~mem_ready) | (if_ce & ~if_ready & ~flush).
REQ-029 mem_rdata/if_data SHALL hold last captured value between transfers.
REQ-030 Late bus_ack seen in IDLE SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, counter 0, bus_req/bus_we/bus_err/if_ready/mem_ready 0, bus_addr/bus_sel/bus_wdata/if_data/mem_rdata 0, regardless of clk.
REQ-032 Reset mid-transfer SHALL abandon transfer without ready pulse; first request after release is treated as new.

Verification
REQ-033 Fetch: if_ce=1, if_addr=32'h0000_0004, ack after 2 cycles with rdata=32'h3401_0020 -> bus_addr=4, bus_we=0, if_data=32'h3401_0020, one if_ready pulse, stallreq low in ready cycle.
REQ-034 Contention: if_ce and mem_ce (we=1, addr=32'h100, sel=4'b0011, wdata=32'hBEEF) same cycle, ack 1 cycle each -> store issued first, mem_ready, then fetch, if_ready; stallreq high throughout until if_ready.
REQ-035 Flush: flush in IF_BUSY, ack 3 cycles later -> IF_DROP, bus_req high until ack, no if_ready; next fetch to new address completes normally.
REQ-036 Timeout: TIMEOUT=4, mem load, no ack -> bus_req drops after 4 cycles, mem_ready with mem_rdata=0, bus_err pulse.
REQ-037 Reset: rst=0 mid MEM_BUSY between edges -> bus_req=0 immediately, no mem_ready; after release with mem_ce held, fresh transfer issued.
